instruction_fetch_unit: RTL
===========================

Name: instruction_fetch_unit

Overview:
- Fetch stage directly upstream of instruction_decoder. Owns the program counter, fetches one 32-bit word from instruction memory through a request/grant/response handshake, and presents {instruction, PC} to the decoder with a valid/ready handshake.
- Accepts PC redirects from the branch unit, including branch targets and bl link jumps.
- PC is word-addressed and increments by 1, consistent with the decoder's PC+1 link value.

Parameters:
- ADDR_W, 32, PC and imem address width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- fetch_en  in  1  permits new fetches; low = halt after the in-flight access completes
- redirect_valid  in  1  branch taken; single-cycle pulse
- redirect_pc  in  ADDR_W  branch target word address
- imem_req  out  1  fetch request
- imem_addr  out  ADDR_W  fetch word address
- imem_gnt  in  1  memory accepted request this cycle
- imem_rvalid  in  1  response data valid
- imem_rdata  in  32  instruction word
- instr_o  out  32  instruction to decoder
- pc_o  out  ADDR_W  address of instr_o
- valid_o  out  1  instr_o/pc_o valid
- ready_i  in  1  decoder consumes when valid_o & ready_i

Behaviour:
- Reset (asynchronous, rst_n=0): pc=RESET_PC, state=IDLE, drop=0, instr_o=0, pc_o=0, valid_o=0. imem_req is 0 during reset.
- imem_req = (state==FETCH). imem_addr = pc at all times.
- At most one memory access is outstanding. imem_addr changes while imem_req is high only on a redirect.
- IDLE: if fetch_en, go to FETCH next cycle.
- FETCH:
  - If imem_gnt, go to WAIT.
  - Else if !fetch_en, go to IDLE.
  - Else stay in FETCH, holding the request.
- WAIT: on imem_rvalid:
  - If drop: discard data, clear drop, go to FETCH (or IDLE if !fetch_en).
  - Else: instr_o<=imem_rdata, pc_o<=pc, valid_o<=1, pc<=pc+1 (mod 2^ADDR_W; all-ones wraps to 0), go to HOLD.
- HOLD: outputs stable while valid_o & !ready_i. On ready_i: valid_o<=0, go to FETCH (or IDLE if !fetch_en).
- Minimum latency: fetch_en in IDLE at cycle 0; req at cycle 1 with gnt; rvalid at cycle 2; valid_o=1 at cycle 3.
- Redirect has highest priority and is handled in any state:
  - pc<=redirect_pc in all cases.
  - IDLE: stay in IDLE.
  - FETCH without gnt: stay in FETCH; the new address appears next cycle.
  - FETCH with gnt in the same cycle: go to WAIT with drop=1.
  - WAIT: stay in WAIT with drop=1. If rvalid arrives in the same cycle, discard it and go to FETCH.
  - HOLD: valid_o<=0, go to FETCH. The held instruction is discarded even if ready_i was high.
- Redirect and ready_i in the same cycle in HOLD: the redirect wins; the handshake does not count as consumed.
- fetch_en low in WAIT: the access completes normally and the instruction is delivered; the stage then goes to IDLE after consumption.
- Reset asserted mid-access: state returns to IDLE. Any late imem_rvalid while in IDLE or FETCH is ignored.
- imem_rvalid outside WAIT is ignored.

Decomposition:
- Shared package kgp_fetch_pkg holds:
  - fetch state enum: IDLE=2'd0, FETCH=2'd1, WAIT=2'd2, HOLD=2'd3.
  - default RESET_PC constant.
  - INSTR_W=32.
- One sub-module: pc_register. It is an ADDR_W register with async active-low reset to RESET_PC, load (redirect) and increment controls; load has priority over increment.

Test Plan:
- Reset release, fetch_en=1, memory with gnt in the request cycle and rvalid one cycle later, ready_i=1 → imem_addr 0,1,2 on successive requests; valid_o at cycle 3 with pc_o=0, instr_o=imem[0]; sequential pc_o 0,1,2.
- ready_i held low for 5 cycles with valid_o=1 → instr_o/pc_o stable, imem_req=0 throughout, pc_o=4 delivered once ready_i rises.
- redirect_valid with redirect_pc=0x40 in WAIT (fetching addr 5) → addr-5 response discarded; next imem_addr=0x40; next delivered pc_o=0x40; no valid_o for addr 5.
- redirect in HOLD with ready_i=1 in the same cycle → valid_o drops next cycle, held instruction not counted as consumed, next fetch address=redirect_pc.
- RESET_PC=2^ADDR_W-1 → first delivered pc_o=all-ones, next fetch address=0.
- fetch_en dropped in WAIT → the in-flight instruction is delivered; no further imem_req; state IDLE. rst_n asserted mid-WAIT → valid_o=0 and pc=RESET_PC immediately.

Source files
------------

// File: rtl/kgp_fetch_pkg.sv
// kgp_fetch_pkg: shared fetch-stage state encoding and constants
package kgp_fetch_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } fetch_state_e;
  localparam int INSTR_W = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'd0;
endpackage

// File: rtl/pc_register.sv
// pc_register: word-addressed program counter with load (priority) and increment
// Ports: clk, rst_n (async, active low) | load_i + load_pc_i: redirect target |
//        inc_i: advance by one word | pc_o: current PC
module pc_register #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_pc_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] pc_o
);
  logic [ADDR_W-1:0] pc_q, pc_d;
  assign pc_d = load_i ? load_pc_i : inc_i ? pc_q + ADDR_W'(1) : pc_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc_q <= RESET_PC;
    else pc_q <= pc_d;
  assign pc_o = pc_q;
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: single-outstanding imem fetch stage feeding the decoder
// Ports: clk, rst_n (async, active low) | fetch_en: allow new fetches |
//        redirect_valid/redirect_pc: branch redirect | imem_req/imem_addr/imem_gnt/
//        imem_rvalid/imem_rdata: memory handshake | instr_o/pc_o/valid_o/ready_i: decoder handshake
module instruction_fetch_unit
  import kgp_fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic               valid_o,
  input  logic               ready_i
);
  fetch_state_e        state_q, state_d;
  logic                drop_q, drop_d;
  logic                valid_q, valid_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [ADDR_W-1:0]   pc_out_q, pc_out_d;
  logic [ADDR_W-1:0]   pc;
  logic                pc_inc;
  pc_register #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (redirect_valid),
    .load_pc_i (redirect_pc),
    .inc_i     (pc_inc),
    .pc_o      (pc)
  );
  always_comb begin
    state_d  = state_q;
    drop_d   = drop_q;
    valid_d  = valid_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    pc_inc   = 1'b0;
    case (state_q)
      IDLE: state_d = (fetch_en && !redirect_valid) ? FETCH : IDLE;
      FETCH:
        if (imem_gnt) begin
          state_d = WAIT;
          drop_d  = redirect_valid;
        end else if (!fetch_en && !redirect_valid) begin
          state_d = IDLE;
        end
      WAIT:
        if (redirect_valid) begin
          // a response landing with the redirect belongs to the old path and closes the access
          drop_d  = !imem_rvalid;
          state_d = imem_rvalid ? FETCH : WAIT;
        end else if (imem_rvalid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = fetch_en ? FETCH : IDLE;
          end else begin
            instr_d  = imem_rdata;
            pc_out_d = pc;
            valid_d  = 1'b1;
            pc_inc   = 1'b1;
            state_d  = HOLD;
          end
        end
      HOLD:
        if (redirect_valid) begin
          valid_d = 1'b0;
          state_d = FETCH;
        end else if (ready_i) begin
          valid_d = 1'b0;
          state_d = fetch_en ? FETCH : IDLE;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      drop_q   <= 1'b0;
      valid_q  <= 1'b0;
      instr_q  <= '0;
      pc_out_q <= '0;
    end else begin
      state_q  <= state_d;
      drop_q   <= drop_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
    end
  assign imem_req  = (state_q == FETCH);
  assign imem_addr = pc;
  assign instr_o   = instr_q;
  assign pc_o      = pc_out_q;
  assign valid_o   = valid_q;
endmodule
